dist_ram_fifo: RTL and testbench
================================

DIST_RAM_FIFO -- requirements
Module: dist_ram_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits, 1..64.
REQ-002 SHALL have parameter DEPTH_LOG2, default 5: log2 of the entry count (32 entries by default), 4..8.
REQ-003 SHALL have parameter IS_CLK_INVERTED, default 1'b0: when 1, all state updates on the falling edge of CLK.
REQ-004 SHALL have port CLK  input  1: single clock for all state.
REQ-005 SHALL have port RST  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port WREN  input  1: write request.
REQ-007 SHALL have port DI  input  WIDTH: write data.
REQ-008 SHALL have port RDEN  input  1: read (pop) request.
REQ-009 SHALL have port DO  output  WIDTH: head-of-queue data.
REQ-010 SHALL have port FULL  output  1: queue holds 2^DEPTH_LOG2 entries.
REQ-011 SHALL have port EMPTY  output  1: queue holds 0 entries.
REQ-012 SHALL have port COUNT  output  DEPTH_LOG2+1: current occupancy.
REQ-013 SHALL have port WRERR  output  1: sticky overflow flag.
REQ-014 SHALL have port RDERR  output  1: sticky underflow flag.

Function
REQ-015 SHALL store data in a 2^DEPTH_LOG2 x WIDTH array, written synchronously and read asynchronously (LUT-RAM style).
REQ-016 SHALL accept a write at the active edge only when WREN=1 and FULL=0: array[wr_ptr] <= DI, wr_ptr increments.
REQ-017 SHALL accept a read at the active edge only when RDEN=1 and EMPTY=0: rd_ptr increments.
REQ-018 SHALL operate first-word-fall-through: DO = array[rd_ptr] combinationally, with no read latency.
REQ-019 SHALL make a word written into an empty queue visible on DO, with EMPTY=0, in the cycle after the write edge; there is no same-cycle DI-to-DO bypass.
REQ-020 SHALL hold DO at the stale array[rd_ptr] value while EMPTY=1; the bench treats DO as don't-care while EMPTY=1.
REQ-021 SHALL implement wr_ptr and rd_ptr as DEPTH_LOG2+1-bit counters that wrap modulo 2^(DEPTH_LOG2+1), addressing with the low DEPTH_LOG2 bits.
REQ-022 SHALL drive COUNT = wr_ptr - rd_ptr (modulo width), EMPTY = (COUNT==0) and FULL = (COUNT==2^DEPTH_LOG2), all derived from registered state only, with no combinational path from WREN/RDEN.
REQ-023 SHALL, when WREN=1 and RDEN=1 on a non-empty, non-full queue, perform both operations so that COUNT is unchanged.
REQ-024 SHALL, when full with WREN=1 and RDEN=1, accept the read, reject the write, and make COUNT decrease by 1.
REQ-025 SHALL, when empty with WREN=1 and RDEN=1, accept the write, reject the read, and make COUNT increase by 1.
REQ-026 SHALL ignore rejected requests, leaving pointers and array contents unchanged.

Reset
REQ-027 SHALL, at an active edge with RST=1, set wr_ptr=0, rd_ptr=0, COUNT=0, EMPTY=1, FULL=0, WRERR=0 and RDERR=0.
REQ-028 SHALL give RST priority over WREN and RDEN at the same edge: no write or read is performed.
REQ-029 SHALL NOT clear array contents on reset; the power-up array content is all zeros.
REQ-030 SHALL, on reset mid-operation, discard all queued words; the queue is empty at the next cycle.

Configuration
REQ-031 SHALL, with macro DIST_RAM_FIFO_ERR_EN defined, set WRERR at the active edge when WREN=1 and FULL=1, and set RDERR when RDEN=1 and EMPTY=1; both flags are sticky until RST.
REQ-032 SHALL, without DIST_RAM_FIFO_ERR_EN, keep ports WRERR and RDERR present and tie them to constant 0, with no error logic generated.

Verification (WIDTH=8, DEPTH_LOG2=5)
REQ-033 SHALL pass: RST, then write 0x11 -> EMPTY=0, COUNT=1 and DO=0x11 the next cycle, not earlier.
REQ-034 SHALL pass: write 0x00..0x1F over 32 cycles -> FULL=1 and COUNT=32; then read 32 times -> DO sequence 0x00..0x1F, after which EMPTY=1.
REQ-035 SHALL pass: with full queue, WREN=1 and RDEN=1, DI=0xAA -> COUNT=31, DO advances to the 2nd word, and 0xAA is not stored.
REQ-036 SHALL pass: with empty queue, WREN=1 and RDEN=1, DI=0x5C -> COUNT=1 and DO=0x5C next cycle.
REQ-037 SHALL pass: 100 write/read cycles with occupancy held at 3 -> pointers wrap with COUNT stable at 3 and data order preserved.
REQ-038 SHALL pass, with DIST_RAM_FIFO_ERR_EN defined: write while full -> WRERR=1 held; read while empty -> RDERR=1 held; RST with WREN=1 -> flags=0, COUNT=0, no write. Without the macro: WRERR=0 and RDERR=0 throughout.

Source files
------------

// File: rtl/dist_ram_fifo.sv
// Purpose : first-word-fall-through FIFO on a LUT-style RAM (sync write, async read).
// Latency : a word written into an empty queue shows on DO, with EMPTY=0, one edge after its write.
// Backpr. : a write while FULL and a read while EMPTY are dropped; with DIST_RAM_FIFO_ERR_EN they set sticky WRERR/RDERR.
//
// Ports:
//   CLK        clock; IS_CLK_INVERTED=1 moves every state update to the falling edge
//   RST        synchronous active-high reset; it wins over WREN/RDEN and leaves the RAM contents alone
//   WREN, DI   write request and write data
//   RDEN       pop request
//   DO         head-of-queue data, read combinationally; stale while EMPTY=1
//   FULL/EMPTY occupancy flags, decoded from the pointers only
//   COUNT      occupancy, 0 .. 2^DEPTH_LOG2
//   WRERR      sticky overflow flag; built only with DIST_RAM_FIFO_ERR_EN, constant 0 otherwise
//   RDERR      sticky underflow flag; built only with DIST_RAM_FIFO_ERR_EN, constant 0 otherwise
// Optional macro: DIST_RAM_FIFO_ERR_EN

module dist_ram_fifo #(
    parameter int   WIDTH           = 8,
    parameter int   DEPTH_LOG2      = 5,
    parameter logic IS_CLK_INVERTED = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WREN,
    input  logic [WIDTH-1:0]      DI,
    input  logic                  RDEN,
    output logic [WIDTH-1:0]      DO,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic [DEPTH_LOG2:0]   COUNT,
    output logic                  WRERR,
    output logic                  RDERR
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Polarity-selected clock; a constant XOR folds away to a plain or inverted clock.
    logic w_clk;
    assign w_clk = CLK ^ IS_CLK_INVERTED;

    // Storage powers up as zeros and is never cleared by reset.
    logic [WIDTH-1:0] r_mem [DEPTH] = '{default: '0};

    // One extra pointer bit tells a full queue apart from an empty one.
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;

    logic [DEPTH_LOG2:0] w_count;
    logic                w_full;
    logic                w_empty;
    logic                w_wr_acc;
    logic                w_rd_acc;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == (DEPTH_LOG2+1)'(DEPTH));
    assign w_empty = (w_count == '0);

    // A full queue still accepts the pop and an empty one still accepts the push,
    // so the qualifiers only ever look at the registered flags.
    assign w_wr_acc = WREN & ~w_full  & ~RST;
    assign w_rd_acc = RDEN & ~w_empty & ~RST;

    always_ff @(posedge w_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= DI;
        end
    end

    always_ff @(posedge w_clk) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign DO    = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
    assign COUNT = w_count;
    assign FULL  = w_full;
    assign EMPTY = w_empty;

`ifdef DIST_RAM_FIFO_ERR_EN
    logic r_wrerr;
    logic r_rderr;

    always_ff @(posedge w_clk) begin
        if (RST) begin
            r_wrerr <= 1'b0;
            r_rderr <= 1'b0;
        end else begin
            if (WREN && w_full) begin
                r_wrerr <= 1'b1;
            end
            if (RDEN && w_empty) begin
                r_rderr <= 1'b1;
            end
        end
    end

    assign WRERR = r_wrerr;
    assign RDERR = r_rderr;
`else
    assign WRERR = 1'b0;
    assign RDERR = 1'b0;
`endif

endmodule

// File: tb/tb_dist_ram_fifo.sv
module tb_dist_ram_fifo;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       WREN = 1'b0;
    logic [7:0] DI = 8'h00;
    logic       RDEN = 1'b0;
    logic [7:0] DO;
    logic       FULL;
    logic       EMPTY;
    logic [5:0] COUNT;
    logic       WRERR;
    logic       RDERR;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q [$];
    logic       exp_wrerr = 1'b0;
    logic       exp_rderr = 1'b0;

    dist_ram_fifo #(
        .WIDTH(8),
        .DEPTH_LOG2(5),
        .IS_CLK_INVERTED(1'b0)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .WREN(WREN),
        .DI(DI),
        .RDEN(RDEN),
        .DO(DO),
        .FULL(FULL),
        .EMPTY(EMPTY),
        .COUNT(COUNT),
        .WRERR(WRERR),
        .RDERR(RDERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted pop must present the oldest expected word.
    always @(negedge CLK) begin
        if (!RST && RDEN && !EMPTY) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got %0h want none", DO);
            end else begin
                chk("pop_data", {24'h0, DO}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    // One clock: inputs held across the edge, released at edge+1.
    task automatic cyc(input logic wr, input logic [7:0] d, input logic rd);
        WREN = wr;
        DI   = d;
        RDEN = rd;
        @(posedge CLK);
        #1;
        WREN = 1'b0;
        RDEN = 1'b0;
    endtask

    task automatic chk_flags(input string nm);
        chk({nm, "_wrerr"}, {31'h0, WRERR}, {31'h0, exp_wrerr});
        chk({nm, "_rderr"}, {31'h0, RDERR}, {31'h0, exp_rderr});
    endtask

    initial begin
        // Reset with a write request pending: no write may happen.
        @(posedge CLK);
        #1;
        RST = 1'b1;
        cyc(1'b1, 8'h77, 1'b1);
        cyc(1'b1, 8'h77, 1'b0);
        RST = 1'b0;
        chk("rst_count", {26'h0, COUNT}, 32'd0);
        chk("rst_empty", {31'h0, EMPTY}, 32'd1);
        chk("rst_full",  {31'h0, FULL},  32'd0);
        chk_flags("rst");

        // First write: visible only after its edge.
        WREN = 1'b1;
        DI   = 8'h11;
        @(negedge CLK);
        chk("pre_wr_empty", {31'h0, EMPTY}, 32'd1);
        chk("pre_wr_count", {26'h0, COUNT}, 32'd0);
        exp_q.push_back(8'h11);
        @(posedge CLK);
        #1;
        WREN = 1'b0;
        chk("wr1_empty", {31'h0, EMPTY}, 32'd0);
        chk("wr1_count", {26'h0, COUNT}, 32'd1);
        chk("wr1_do",    {24'h0, DO},    32'h11);
        cyc(1'b0, 8'h00, 1'b1);
        chk("rd1_empty", {31'h0, EMPTY}, 32'd1);

        // Fill 0x00..0x1F, then drain.
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(8'(i));
            cyc(1'b1, 8'(i), 1'b0);
        end
        chk("fill_full",  {31'h0, FULL},  32'd1);
        chk("fill_count", {26'h0, COUNT}, 32'd32);
        for (int i = 0; i < 32; i++) cyc(1'b0, 8'h00, 1'b1);
        chk("drain_empty", {31'h0, EMPTY}, 32'd1);
        chk("drain_count", {26'h0, COUNT}, 32'd0);

        // Full queue with simultaneous write and read: read wins, 0xAA dropped.
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(8'(8'h40 + i));
            cyc(1'b1, 8'(8'h40 + i), 1'b0);
        end
        chk("full2_full", {31'h0, FULL}, 32'd1);
        cyc(1'b1, 8'hAA, 1'b1);
`ifdef DIST_RAM_FIFO_ERR_EN
        exp_wrerr = 1'b1;
`endif
        chk("fullrw_count", {26'h0, COUNT}, 32'd31);
        chk("fullrw_do",    {24'h0, DO},    32'h41);
        chk("fullrw_full",  {31'h0, FULL},  32'd0);
        chk_flags("fullrw");
        for (int i = 0; i < 31; i++) cyc(1'b0, 8'h00, 1'b1);
        chk("fullrw_drain", {31'h0, EMPTY}, 32'd1);

        // Empty queue with simultaneous write and read: write wins.
        exp_q.push_back(8'h5C);
        cyc(1'b1, 8'h5C, 1'b1);
`ifdef DIST_RAM_FIFO_ERR_EN
        exp_rderr = 1'b1;
`endif
        chk("emptyrw_count", {26'h0, COUNT}, 32'd1);
        chk("emptyrw_do",    {24'h0, DO},    32'h5C);
        chk_flags("emptyrw");
        cyc(1'b0, 8'h00, 1'b1);

        // Steady occupancy of 3 over 100 cycles, wrapping both pointers.
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'(8'h80 + i));
            cyc(1'b1, 8'(8'h80 + i), 1'b0);
        end
        for (int i = 0; i < 100; i++) begin
            exp_q.push_back(8'(8'h83 + i));
            cyc(1'b1, 8'(8'h83 + i), 1'b1);
            chk("steady_count", {26'h0, COUNT}, 32'd3);
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1);
        chk("steady_empty", {31'h0, EMPTY}, 32'd1);

        // Read while empty, then sticky flags over idle cycles.
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("idle_count", {26'h0, COUNT}, 32'd0);
        chk_flags("sticky");

        // Reset mid-operation with a write pending discards everything.
        cyc(1'b1, 8'h21, 1'b0);
        cyc(1'b1, 8'h22, 1'b0);
        chk("pre_rst_count", {26'h0, COUNT}, 32'd2);
        RST = 1'b1;
        cyc(1'b1, 8'h99, 1'b0);
        RST = 1'b0;
        exp_wrerr = 1'b0;
        exp_rderr = 1'b0;
        chk("mrst_count", {26'h0, COUNT}, 32'd0);
        chk("mrst_empty", {31'h0, EMPTY}, 32'd1);
        chk_flags("mrst");
        exp_q.push_back(8'h33);
        cyc(1'b1, 8'h33, 1'b0);
        chk("post_rst_do", {24'h0, DO}, 32'h33);
        cyc(1'b0, 8'h00, 1'b1);
        chk("post_rst_empty", {31'h0, EMPTY}, 32'd1);

        chk("sb_leftover", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
